// File: rtl/ddr3_burst_sched.sv
// Round-robin burst scheduler sharing one DDR3 UI port between capture write-back and display read-out.
// Grant 1 cycle after request, first app_en 1 cycle after grant; command and write-data paths stall independently on app_rdy / app_wdf_rdy.
module ddr3_burst_sched #(
  parameter int ADDR_W        = 28,
  parameter int CNT_W         = 11,
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int ADDR_STEP     = 8
) (
  input  logic              clk,
  input  logic              g_rst_p,
  input  logic              init_calib_complete,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] app_addr_wr_min,
  input  logic [ADDR_W-1:0] app_addr_wr_max,
  input  logic [ADDR_W-1:0] app_addr_rd_min,
  input  logic [ADDR_W-1:0] app_addr_rd_max,
  input  logic [7:0]        wr_bust_len,
  input  logic [7:0]        rd_bust_len,
  input  logic [CNT_W-1:0]  wfifo_rcount,
  input  logic [CNT_W-1:0]  rfifo_wcount,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic              wfifo_rden,
  output logic              rfifo_wren,
  output logic              busy
);

  typedef enum logic [1:0] {WAIT_CAL, IDLE, WR, RD} state_t;

  localparam logic [CNT_W:0] RD_DEPTH_W = (CNT_W+1)'(RD_FIFO_DEPTH);

  state_t            state_q, state_d;
  logic              last_rd_q, last_rd_d;
  logic [7:0]        cmd_cnt_q, cmd_cnt_d;
  logic [7:0]        dat_cnt_q, dat_cnt_d;
  logic [7:0]        rd_rcv_q, rd_rcv_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]        wl_sync_q, wl_sync_d;
  logic [2:0]        rl_sync_q, rl_sync_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              app_en_q, app_en_d;
  logic [2:0]        app_cmd_q, app_cmd_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic              app_wdf_wren_q, app_wdf_wren_d;
  logic              busy_q, busy_d;

  logic wr_req, rd_req, wr_edge, rd_edge, cmd_hs, dat_hs;

  function automatic logic [ADDR_W-1:0] wrap_next(input logic [ADDR_W-1:0] p,
                                                   input logic [ADDR_W-1:0] mn,
                                                   input logic [ADDR_W-1:0] mx);
    logic [ADDR_W:0] nxt;
    nxt = {1'b0, p} + (ADDR_W+1)'(ADDR_STEP);
    return (nxt >= {1'b0, mx}) ? mn : nxt[ADDR_W-1:0];
  endfunction

  assign wr_req  = ({1'b0, wfifo_rcount} >= (CNT_W+1)'(wr_bust_len));
  assign rd_req  = (({1'b0, rfifo_wcount} + (CNT_W+1)'(rd_bust_len)) <= RD_DEPTH_W);
  assign wr_edge = wl_sync_q[1] & ~wl_sync_q[2];
  assign rd_edge = rl_sync_q[1] & ~rl_sync_q[2];
  assign cmd_hs  = app_en_q & app_rdy;
  assign dat_hs  = app_wdf_wren_q & app_wdf_rdy;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    cmd_cnt_d = cmd_cnt_q;
    dat_cnt_d = dat_cnt_q;
    rd_rcv_d  = rd_rcv_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wl_sync_d = {wl_sync_q[1:0], wr_load};
    rl_sync_d = {rl_sync_q[1:0], rd_load};
    wr_pend_d = wr_pend_q | wr_edge;
    rd_pend_d = rd_pend_q | rd_edge;

    case (state_q)
      WAIT_CAL, IDLE: begin
        // Frame-sync reloads only land between bursts; an edge in this very cycle stays pending.
        if (wr_pend_q) begin
          wr_ptr_d  = app_addr_wr_min;
          wr_pend_d = wr_edge;
        end
        if (rd_pend_q) begin
          rd_ptr_d  = app_addr_rd_min;
          rd_pend_d = rd_edge;
        end
        cmd_cnt_d = '0;
        dat_cnt_d = '0;
        rd_rcv_d  = '0;
        if (state_q == WAIT_CAL) begin
          if (init_calib_complete) state_d = IDLE;
        end else if (!init_calib_complete) begin
          state_d = WAIT_CAL;
        end else if (wr_req && (!rd_req || last_rd_q)) begin
          state_d   = WR;
          last_rd_d = 1'b0;
        end else if (rd_req) begin
          state_d   = RD;
          last_rd_d = 1'b1;
        end
      end
      WR: begin
        if (cmd_hs) begin
          cmd_cnt_d = cmd_cnt_q + 8'd1;
          wr_ptr_d  = wrap_next(wr_ptr_q, app_addr_wr_min, app_addr_wr_max);
        end
        if (dat_hs) dat_cnt_d = dat_cnt_q + 8'd1;
        if (cmd_cnt_q == wr_bust_len && dat_cnt_q == wr_bust_len) state_d = IDLE;
      end
      RD: begin
        if (cmd_hs) begin
          cmd_cnt_d = cmd_cnt_q + 8'd1;
          rd_ptr_d  = wrap_next(rd_ptr_q, app_addr_rd_min, app_addr_rd_max);
        end
        if (app_rd_data_valid) rd_rcv_d = rd_rcv_q + 8'd1;
        if (cmd_cnt_q == rd_bust_len && rd_rcv_q == rd_bust_len) state_d = IDLE;
      end
      default: state_d = WAIT_CAL;
    endcase

    // Outputs are registered: look one cycle ahead using the updated counters.
    app_en_d       = 1'b0;
    app_wdf_wren_d = 1'b0;
    app_cmd_d      = 3'd0;
    if (state_q == WR && state_d == WR) begin
      app_en_d       = (cmd_cnt_d < wr_bust_len);
      app_wdf_wren_d = (dat_cnt_d < wr_bust_len);
    end
    if (state_q == RD && state_d == RD) begin
      app_en_d  = (cmd_cnt_d < rd_bust_len);
      app_cmd_d = 3'd1;
    end
    app_addr_d = '0;
    if (app_en_d) app_addr_d = (state_q == RD) ? rd_ptr_d : wr_ptr_d;
    busy_d = (state_d == WR) || (state_d == RD);
  end

  always_ff @(posedge clk or posedge g_rst_p) begin
    if (g_rst_p) begin
      state_q        <= WAIT_CAL;
      last_rd_q      <= 1'b1;
      cmd_cnt_q      <= '0;
      dat_cnt_q      <= '0;
      rd_rcv_q       <= '0;
      wr_ptr_q       <= app_addr_wr_min;
      rd_ptr_q       <= app_addr_rd_min;
      wl_sync_q      <= '0;
      rl_sync_q      <= '0;
      wr_pend_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      app_en_q       <= 1'b0;
      app_cmd_q      <= 3'd0;
      app_addr_q     <= '0;
      app_wdf_wren_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_rd_q      <= last_rd_d;
      cmd_cnt_q      <= cmd_cnt_d;
      dat_cnt_q      <= dat_cnt_d;
      rd_rcv_q       <= rd_rcv_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wl_sync_q      <= wl_sync_d;
      rl_sync_q      <= rl_sync_d;
      wr_pend_q      <= wr_pend_d;
      rd_pend_q      <= rd_pend_d;
      app_en_q       <= app_en_d;
      app_cmd_q      <= app_cmd_d;
      app_addr_q     <= app_addr_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      busy_q         <= busy_d;
    end
  end

  assign app_en       = app_en_q;
  assign app_cmd      = app_cmd_q;
  assign app_addr     = app_addr_q;
  assign app_wdf_wren = app_wdf_wren_q;
  assign app_wdf_end  = app_wdf_wren_q;
  assign wfifo_rden   = dat_hs;
  assign rfifo_wren   = app_rd_data_valid;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ddr3_burst_sched.sv
// Directed bench for ddr3_burst_sched: vector table of 4-beat bursts plus hand-written corner sequences.
module tb_ddr3_burst_sched;
  localparam int AW = 28;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          g_rst_p = 1'b1, calib = 1'b0, wr_load = 1'b0, rd_load = 1'b0;
  logic [AW-1:0] wmin = '0, wmax = AW'(1 << 20), rmin = '0, rmax = AW'(1 << 20);
  logic [7:0]    wlen = 8'd160, rlen = 8'd4;
  logic [CW-1:0] wfc = CW'(200), rfc = CW'(1024);
  logic          app_rdy = 1'b1, app_wdf_rdy = 1'b1, app_rd_data_valid = 1'b0;
  logic          app_en, app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren, busy;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;

  ddr3_burst_sched dut (
    .clk(clk), .g_rst_p(g_rst_p), .init_calib_complete(calib),
    .wr_load(wr_load), .rd_load(rd_load),
    .app_addr_wr_min(wmin), .app_addr_wr_max(wmax),
    .app_addr_rd_min(rmin), .app_addr_rd_max(rmax),
    .wr_bust_len(wlen), .rd_bust_len(rlen),
    .wfifo_rcount(wfc), .rfifo_wcount(rfc),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .wfifo_rden(wfifo_rden), .rfifo_wren(rfifo_wren), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  logic [AW-1:0] addr_q[$];
  int  types[$];
  int  due_q[$];
  int  n_en_cyc = 0, n_dat = 0, n_rd = 0, last_cmd_cyc = 0, busy_fall_cyc = 0, rd_lat = 3;
  bit  first_cmd = 1'b0, rand_rdy = 1'b0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc++;

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (busy && !busy_prev) first_cmd = 1'b1;
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    busy_prev = busy;
    if (app_en) n_en_cyc++;
    if (app_en && app_rdy) begin
      addr_q.push_back(app_addr);
      last_cmd_cyc = cyc;
      if (first_cmd) begin
        types.push_back(int'(app_cmd));
        first_cmd = 1'b0;
      end
      if (app_cmd == 3'd1) due_q.push_back(cyc + rd_lat);
    end
    if (wfifo_rden) n_dat++;
    if (rfifo_wren) n_rd++;
    if (g_rst_p) due_q.delete();
  end

  // Read-data responder and ready generator.
  always @(posedge clk) begin
    #1;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      app_rd_data_valid = 1'b1;
      void'(due_q.pop_front());
    end else begin
      app_rd_data_valid = 1'b0;
    end
    app_rdy     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    app_wdf_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete();
    types.delete();
    n_en_cyc = 0;
    n_dat = 0;
    n_rd = 0;
  endtask

  task automatic wait_busy(input logic v, input int bound, input string nm);
    int k = 0;
    while (busy !== v && k < bound) begin
      tick();
      k++;
    end
    chk(nm, longint'(busy), longint'(v));
  endtask

  task automatic run_burst(input bit is_wr, input logic [7:0] len);
    clear_mon();
    if (is_wr) begin
      wlen = len;
      wfc  = CW'(len);
    end else begin
      rlen = len;
      rfc  = CW'(1024 - int'(len));
    end
    wait_busy(1'b1, 20, "burst_start");
    wfc = '0;
    rfc = CW'(1024);
    wait_busy(1'b0, 3000, "burst_end");
    tick(30);
  endtask

  function automatic longint addr_at(input int i);
    return (i < addr_q.size()) ? longint'(addr_q[i]) : -1;
  endfunction

  task automatic pulse(input bit is_wr);
    if (is_wr) wr_load = 1'b1; else rd_load = 1'b1;
    tick(3);
    wr_load = 1'b0;
    rd_load = 1'b0;
    tick(4);
  endtask

  typedef struct {
    bit is_wr;
    bit load;
    int mn;
    int mx;
    int a[4];
  } vec_t;

  function automatic vec_t mk(input bit w, input bit l, input int mn, input int mx,
                              input int a0, input int a1, input int a2, input int a3);
    vec_t v;
    v.is_wr = w; v.load = l; v.mn = mn; v.mx = mx;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    int errs;
    tbl[0] = mk(1, 1, 0,    40,   0,    8,    16,   24);
    tbl[1] = mk(1, 0, 0,    40,   32,   0,    8,    16);
    tbl[2] = mk(0, 1, 1000, 2000, 1000, 1008, 1016, 1024);
    tbl[3] = mk(0, 0, 1000, 2000, 1032, 1040, 1048, 1056);
    tbl[4] = mk(0, 0, 1000, 1050, 1064, 1000, 1008, 1016);
    tbl[5] = mk(1, 0, 100,  4096, 24,   32,   40,   48);
    tbl[6] = mk(1, 1, 100,  4096, 100,  108,  116,  124);

    // Reset state.
    tick(3);
    chk("rst_app_en", app_en, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_wdf_wren", app_wdf_wren, 0);
    chk("rst_busy", busy, 0);
    g_rst_p = 1'b0;

    // Calibration held low: no traffic despite a full write FIFO.
    clear_mon();
    tick(50);
    chk("nocal_app_en", n_en_cyc, 0);
    chk("nocal_busy", busy, 0);

    // Long write burst once calibrated.
    calib = 1'b1;
    run_burst(1'b1, 8'd160);
    chk("long_ncmd", addr_q.size(), 160);
    chk("long_ndat", n_dat, 160);
    chk("long_first", addr_at(0), 0);
    chk("long_last", addr_at(159), 1272);
    errs = 0;
    for (int i = 0; i < 160; i++) if (addr_at(i) != longint'(i * 8)) errs++;
    chk("long_contig", errs, 0);

    // Round robin from reset: WR first, then alternate.
    g_rst_p = 1'b1;
    tick(2);
    g_rst_p = 1'b0;
    wmax = AW'(4096);
    rmax = AW'(4096);
    wlen = 8'd4;
    rlen = 8'd4;
    clear_mon();
    wfc = CW'(4);
    rfc = CW'(1020);
    for (int k = 0; k < 400 && types.size() < 4; k++) tick();
    wfc = '0;
    rfc = CW'(1024);
    wait_busy(1'b0, 200, "rr_end");
    tick(30);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), (i < types.size()) ? types[i] : -1, i % 2);

    // One beat short of either request threshold: nothing is granted.
    clear_mon();
    wfc = CW'(3);
    rfc = CW'(1021);
    tick(20);
    chk("thresh_no_en", n_en_cyc, 0);
    chk("thresh_busy", busy, 0);
    wfc = '0;
    rfc = CW'(1024);
    tick(2);

    // Vector table of 4-beat bursts; pointer state carries from row to row.
    for (int r = 0; r < 7; r++) begin
      if (tbl[r].is_wr) begin
        wmin = AW'(tbl[r].mn);
        wmax = AW'(tbl[r].mx);
      end else begin
        rmin = AW'(tbl[r].mn);
        rmax = AW'(tbl[r].mx);
      end
      if (tbl[r].load) pulse(tbl[r].is_wr);
      run_burst(tbl[r].is_wr, 8'd4);
      chk($sformatf("v%0d_ncmd", r), addr_q.size(), 4);
      chk($sformatf("v%0d_type", r), (types.size() > 0) ? types[0] : -1, tbl[r].is_wr ? 0 : 1);
      chk($sformatf("v%0d_ndat", r), n_dat, tbl[r].is_wr ? 4 : 0);
      chk($sformatf("v%0d_nrd", r), n_rd, tbl[r].is_wr ? 0 : 4);
      for (int i = 0; i < 4; i++)
        chk($sformatf("v%0d_addr%0d", r, i), addr_at(i), tbl[r].a[i]);
    end

    // Frame sync mid-burst is deferred to the next burst.
    wmin = AW'(500);
    fork
      run_burst(1'b1, 8'd16);
      begin
        for (int k = 0; k < 20 && !busy; k++) tick();
        tick(3);
        pulse(1'b1);
      end
    join
    chk("fs_ncmd", addr_q.size(), 16);
    errs = 0;
    for (int i = 0; i < 16; i++) if (addr_at(i) != longint'(132 + i * 8)) errs++;
    chk("fs_unchanged", errs, 0);
    run_burst(1'b1, 8'd4);
    chk("fs_next_first", addr_at(0), 500);

    // Late read data keeps the scheduler in RD until the last beat.
    rd_lat = 20;
    run_burst(1'b0, 8'd4);
    chk("late_nrd", n_rd, 4);
    chk("late_hold", busy_fall_cyc - last_cmd_cyc, 22);
    rd_lat = 3;

    // Random ready stalls on both write paths.
    rand_rdy = 1'b1;
    run_burst(1'b1, 8'd8);
    chk("rnd_ncmd", addr_q.size(), 8);
    chk("rnd_ndat", n_dat, 8);
    chk("rnd_first", addr_at(0), 532);
    chk("rnd_last", addr_at(7), 588);

    // Reset in the middle of a burst.
    clear_mon();
    wlen = 8'd8;
    wfc  = CW'(8);
    wait_busy(1'b1, 20, "mid_start");
    tick(3);
    g_rst_p = 1'b1;
    tick();
    chk("mrst_app_en", app_en, 0);
    chk("mrst_app_cmd", app_cmd, 0);
    chk("mrst_app_addr", app_addr, 0);
    chk("mrst_wdf_wren", app_wdf_wren, 0);
    chk("mrst_wdf_end", app_wdf_end, 0);
    chk("mrst_wfifo_rden", wfifo_rden, 0);
    chk("mrst_busy", busy, 0);
    wfc = '0;
    rand_rdy = 1'b0;
    tick();
    g_rst_p = 1'b0;
    tick(3);
    run_burst(1'b1, 8'd4);
    chk("mrst_wr_min", addr_at(0), 500);
    run_burst(1'b0, 8'd4);
    chk("mrst_rd_min", addr_at(0), 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
